// File: rtl/demux_pkg.sv
// Shared constants and types for the round-robin demux dispatcher.
package demux_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  typedef enum logic {
    EMPTY,
    HOLD
  } dispatch_state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// First set bit of a 4-bit mask, searching upward from ptr with wrap-around.
module rr_pick4
  import demux_pkg::*;
(
  input  logic [SELW-1:0] ptr,
  input  logic [NCH-1:0]  mask,
  output logic [SELW-1:0] target,
  output logic            found
);

  logic [SELW-1:0] idx;

  always_comb begin
    target = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      // SELW-bit addition wraps modulo NCH
      idx = ptr + SELW'(k);
      if (!found && mask[idx]) begin
        found  = 1'b1;
        target = idx;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Steers a valid/ready word stream onto one of four channels (round-robin
// over an enable mask or fixed select), holding each word until accepted.
module demux_rr_dispatcher #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  input  logic [SELW-1:0]  cfg_sel,
  input  logic [NCH-1:0]   chan_en,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic             busy,
  output logic [CNTW-1:0]  word_cnt
);

  import demux_pkg::*;

  dispatch_state_t state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_target;
  logic            rr_found;
  logic [SELW-1:0] target;
  logic            found;
  logic            deliver;
  logic            load;

  rr_pick4 u_pick (
    .ptr    (ptr),
    .mask   (chan_en),
    .target (rr_target),
    .found  (rr_found)
  );

  always_comb begin
    target   = rr_target;
    found    = rr_found;
    if (mode == MODE_FIXED) begin
      target = cfg_sel;
      found  = chan_en[cfg_sel];
    end
    deliver  = (state == HOLD) && out_ready[out_sel];
    // Accepting while the held word leaves gives one word per cycle
    in_ready = !rst && found && ((state == EMPTY) || deliver);
    load     = in_valid && in_ready;
  end

  assign busy = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ptr       <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= '0;
      word_cnt  <= '0;
    end else begin
      if (load) begin
        out_data  <= in_data;
        out_sel   <= target;
        out_valid <= NCH'(1) << target;
        state     <= HOLD;
        if (mode == MODE_RR)
          ptr <= target + SELW'(1);
      end else if (deliver) begin
        out_valid <= '0;
        state     <= EMPTY;
      end
      if (deliver && (word_cnt != '1))
        word_cnt <= word_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher with a transaction-level model.
module tb_demux_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        mode;
  logic [1:0]  cfg_sel;
  logic [3:0]  chan_en;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        busy;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  demux_rr_dispatcher #(.WIDTH(8), .NCH(4), .SELW(2), .CNTW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .cfg_sel   (cfg_sel),
    .chan_en   (chan_en),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a held slot, pointer and counter updated per transfer rules
  bit        m_started = 0;
  bit        m_held;
  int        m_data, m_sel, m_ptr, m_cnt;

  function automatic void pick(output bit ok, output int t);
    ok = 0;
    t  = 0;
    if (mode) begin
      ok = chan_en[cfg_sel];
      t  = int'(cfg_sel);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!ok && chan_en[(m_ptr + i) % 4]) begin
          ok = 1;
          t  = (m_ptr + i) % 4;
        end
      end
    end
  endfunction

  function automatic bit m_deliver();
    return m_held && out_ready[m_sel];
  endfunction

  function automatic bit m_ready();
    bit ok;
    int t;
    pick(ok, t);
    return !rst && ok && (!m_held || m_deliver());
  endfunction

  always @(posedge clk) begin
    bit ok;
    int t;
    bit dl, rdy;
    cyc++;
    if (rst) begin
      m_started = 1;
      m_held = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_started) begin
      pick(ok, t);
      dl  = m_deliver();
      rdy = m_ready();
      if (dl && m_cnt < 65535) m_cnt++;
      if (in_valid && rdy) begin
        m_held = 1;
        m_data = int'(in_data);
        m_sel  = t;
        if (!mode) m_ptr = (t + 1) % 4;
      end else if (dl) begin
        m_held = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready",  32'(in_ready),  32'(m_ready()));
      chk("out_valid", 32'(out_valid), m_held ? (32'd1 << m_sel) : 32'd0);
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("out_sel",   32'(out_sel),   32'(m_sel));
      chk("busy",      32'(busy),      32'(m_held));
      chk("word_cnt",  32'(word_cnt),  32'(m_cnt));
    end
  end

  // Delivery log read from the DUT ports, pinned against literal sequences
  int log_sel[$];
  int log_data[$];
  always @(posedge clk) begin
    if (!rst && busy === 1'b1 && out_ready[out_sel] === 1'b1) begin
      log_sel.push_back(int'(out_sel));
      log_data.push_back(int'(out_data));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 20) begin
        errors++;
        $display("FAIL send_timeout: word %h not accepted in 20 cycles", d);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_log(input string name, input int exp_sel[], input int exp_data[]);
    chk({name, "_count"}, 32'(log_sel.size()), 32'(exp_sel.size()));
    for (int i = 0; i < exp_sel.size() && i < log_sel.size(); i++) begin
      chk({name, "_sel"},  32'(log_sel[i]),  32'(exp_sel[i]));
      chk({name, "_data"}, 32'(log_data[i]), 32'(exp_data[i]));
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0;
    cfg_sel = '0; chan_en = '0; out_ready = '0;
    step(2);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    // Round-robin stream, back-to-back
    @(posedge clk); #1;
    chan_en = 4'b1111; mode = 1'b0; out_ready = 4'b1111;
    log_sel.delete(); log_data.delete();
    t0 = cyc;
    send(8'hA0);
    chk("rr_first_valid", 32'(out_valid), 32'b0001);
    for (int w = 1; w < 6; w++) send(8'hA0 + 8'(w));
    chk("rr_throughput", 32'(cyc - t0), 32'd6);
    step(2);
    chk("rr_cnt", 32'(word_cnt), 32'd6);
    chk_log("rr", '{0, 1, 2, 3, 0, 1}, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});

    // Mask skipping from ptr=0
    do_reset();
    chan_en = 4'b1010;
    log_sel.delete(); log_data.delete();
    send(8'h11); chk("mask_v0", 32'(out_valid), 32'b0010);
    send(8'h22); chk("mask_v1", 32'(out_valid), 32'b1000);
    send(8'h33); chk("mask_v2", 32'(out_valid), 32'b0010);
    step(2);
    chk_log("mask", '{1, 3, 1}, '{8'h11, 8'h22, 8'h33});

    // Backpressure on ch2 while the enable mask changes underneath
    mode = 1'b1; cfg_sel = 2'd2; chan_en = 4'b1111; out_ready = 4'b1011;
    send(8'h5C);
    chan_en = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'b0100);
      chk("bp_data", 32'(out_data), 32'h5C);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 4'b1111;
    step(1);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_cnt", 32'(word_cnt), 32'd4);

    // Fixed mode onto ch3, then ch3 disabled
    chan_en = 4'b1111; cfg_sel = 2'd3;
    log_sel.delete(); log_data.delete();
    send(8'h01);
    send(8'h02);
    step(2);
    chk_log("fixed", '{3, 3}, '{8'h01, 8'h02});
    chan_en = 4'b0111; in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fixed_dis_ready", 32'(in_ready), 32'd0);
      chk("fixed_dis_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    chk("fixed_dis_cnt", 32'(word_cnt), 32'd6);

    // Reset while holding: held word is dropped, ptr restarts at 0
    do_reset();
    mode = 1'b0; chan_en = 4'b0010; out_ready = 4'b0000;
    log_sel.delete(); log_data.delete();
    send(8'h77);
    chk("hold_valid", 32'(out_valid), 32'b0010);
    chk("hold_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(word_cnt), 32'd0);
    chan_en = 4'b1111; out_ready = 4'b1111;
    send(8'h88);
    chk("midrst_sel", 32'(out_sel), 32'd0);
    chk("midrst_next_valid", 32'(out_valid), 32'b0001);
    step(2);
    chk_log("midrst", '{0}, '{8'h88});

    // Counter saturation after 65537 deliveries
    do_reset();
    log_sel.delete(); log_data.delete();
    in_valid = 1'b1; in_data = 8'h5A;
    step(65537);
    in_valid = 1'b0;
    step(1);
    chk("sat_cnt", 32'(word_cnt), 32'hFFFF);
    log_sel.delete(); log_data.delete();
    send(8'hC3);
    step(2);
    chk("sat_hold", 32'(word_cnt), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
